// File: rtl/crc8_frame_pkg.sv
`default_nettype none
// ============================================================================
// crc8_frame_pkg : shared types and defaults for the CRC-8 frame transmitter
// Revision 1.0
// ============================================================================
package crc8_frame_pkg;

  typedef enum logic [1:0] {
    PAYLOAD  = 2'd0,
    APPEND   = 2'd1,
    DRAIN    = 2'd2,
    GAP_WAIT = 2'd3
  } state_t;

  localparam logic [7:0] C_CRC_POLY    = 8'h1D;
  localparam logic [7:0] C_CRC_INIT    = 8'hFF;
  localparam logic [7:0] C_CRC_XOR_OUT = 8'h00;
  localparam int         FRAME_CNT_W   = 16;

endpackage
`default_nettype wire

// File: rtl/crc8_frame_tx_if.sv
`default_nettype none
// ============================================================================
// crc8_frame_tx_if : payload in, framed bytes out, plus status of the framer
// Revision 1.0
// ============================================================================
interface crc8_frame_tx_if;

  logic                                 s_valid_i;
  logic [7:0]                           s_data_i;
  logic                                 s_last_i;
  logic                                 s_ready_o;
  logic                                 m_valid_o;
  logic [7:0]                           m_data_o;
  logic                                 m_last_o;
  logic                                 m_ready_i;
  logic                                 busy_o;
  logic                                 err_oversize_o;
  logic [crc8_frame_pkg::FRAME_CNT_W-1:0] frame_count_o;

  // Framer side
  modport slave (
    input  s_valid_i, s_data_i, s_last_i, m_ready_i,
    output s_ready_o, m_valid_o, m_data_o, m_last_o,
    output busy_o, err_oversize_o, frame_count_o
  );

  // Source / sink side
  modport master (
    output s_valid_i, s_data_i, s_last_i, m_ready_i,
    input  s_ready_o, m_valid_o, m_data_o, m_last_o,
    input  busy_o, err_oversize_o, frame_count_o
  );

endinterface
`default_nettype wire

// File: rtl/crc8_frame_tx_crc_calc.sv
`default_nettype none
// ============================================================================
// crc_calc : parameterised serial-in-parallel CRC engine with registered result
// Revision 1.0
// ============================================================================
module crc_calc
  import crc8_frame_pkg::*;
#(
  parameter int                  DATA_WIDTH = 8,
  parameter int                  CRC_SIZE   = 8,
  parameter logic [CRC_SIZE-1:0] POLY       = CRC_SIZE'(C_CRC_POLY),
  parameter logic [CRC_SIZE-1:0] INIT       = CRC_SIZE'(C_CRC_INIT),
  parameter bit                  REF_IN     = 1'b1,
  parameter bit                  REF_OUT    = 1'b1,
  parameter logic [CRC_SIZE-1:0] XOR_OUT    = CRC_SIZE'(C_CRC_XOR_OUT)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  soft_reset_i,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [CRC_SIZE-1:0]   crc_o
);

  logic [CRC_SIZE-1:0]   r_crc;
  logic [CRC_SIZE-1:0]   r_crc_out;
  logic [CRC_SIZE-1:0]   w_base;
  logic [CRC_SIZE-1:0]   w_next;
  logic [DATA_WIDTH-1:0] w_din;

  function automatic logic [DATA_WIDTH-1:0] refl_data(input logic [DATA_WIDTH-1:0] d);
    logic [DATA_WIDTH-1:0] r;
    for (int i = 0; i < DATA_WIDTH; i++) r[i] = d[DATA_WIDTH-1-i];
    return r;
  endfunction

  function automatic logic [CRC_SIZE-1:0] refl_crc(input logic [CRC_SIZE-1:0] c);
    logic [CRC_SIZE-1:0] r;
    for (int i = 0; i < CRC_SIZE; i++) r[i] = c[CRC_SIZE-1-i];
    return r;
  endfunction

  // Register is kept in the unreflected domain; reflection lives on the edges
  function automatic logic [CRC_SIZE-1:0] crc_step(input logic [CRC_SIZE-1:0]   c,
                                                   input logic [DATA_WIDTH-1:0] d);
    logic fb;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      fb = c[CRC_SIZE-1] ^ d[i];
      c  = {c[CRC_SIZE-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
    return c;
  endfunction

  function automatic logic [CRC_SIZE-1:0] finalize(input logic [CRC_SIZE-1:0] c);
    return (REF_OUT ? refl_crc(c) : c) ^ XOR_OUT;
  endfunction

  always_comb begin
    w_din  = REF_IN ? refl_data(data_i) : data_i;
    w_base = soft_reset_i ? INIT : r_crc;
    w_next = valid_i ? crc_step(w_base, w_din) : w_base;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_crc     <= INIT;
      r_crc_out <= finalize(INIT);
    end else begin
      r_crc     <= w_next;
      r_crc_out <= finalize(w_next);
    end
  end

  assign crc_o = r_crc_out;

endmodule
`default_nettype wire

// File: rtl/crc8_frame_tx.sv
`default_nettype none
// ============================================================================
// crc8_frame_tx : frames a byte stream, appending a CRC-8 after each last byte
// Revision 1.0
// ============================================================================
module crc8_frame_tx
  import crc8_frame_pkg::*;
#(
  parameter logic [7:0] POLY    = C_CRC_POLY,
  parameter logic [7:0] INIT    = C_CRC_INIT,
  parameter bit         REF_IN  = 1'b1,
  parameter bit         REF_OUT = 1'b1,
  parameter logic [7:0] XOR_OUT = C_CRC_XOR_OUT,
  parameter int         MAX_LEN = 256,
  parameter int         GAP     = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  crc8_frame_tx_if.slave   bus
);

  localparam int CNT_W = $clog2(MAX_LEN + 1);
  localparam int GAP_W = (GAP < 2) ? 1 : $clog2(GAP + 1);
  localparam logic [CNT_W-1:0] C_MAX_LEN = CNT_W'(MAX_LEN);
  localparam logic [GAP_W-1:0] C_GAP     = GAP_W'(GAP);
  localparam logic [GAP_W-1:0] C_GAP_ONE = GAP_W'(1);

  state_t                 r_state;
  logic [CNT_W-1:0]       r_byte_cnt;
  logic [GAP_W-1:0]       r_gap_cnt;
  logic                   r_m_valid;
  logic [7:0]             r_m_data;
  logic                   r_m_last;
  logic                   r_err;
  logic [FRAME_CNT_W-1:0] r_frame_cnt;

  logic                   w_slot_free;
  logic                   w_s_ready;
  logic                   w_accept;
  logic                   w_soft_reset;
  logic [CNT_W-1:0]       w_cnt_next;
  logic                   w_hit_max;
  logic [7:0]             w_crc;
  logic                   w_crc_rst;

  assign w_slot_free  = !r_m_valid | bus.m_ready_i;
  assign w_s_ready    = rst_ni & (r_state == PAYLOAD) & w_slot_free;
  assign w_accept     = bus.s_valid_i & w_s_ready;
  assign w_soft_reset = (r_state == APPEND) & w_slot_free;
  assign w_cnt_next   = r_byte_cnt + 1'b1;
  assign w_hit_max    = (w_cnt_next == C_MAX_LEN);
  assign w_crc_rst    = ~rst_ni;

  crc_calc #(
    .DATA_WIDTH (8),
    .CRC_SIZE   (8),
    .POLY       (POLY),
    .INIT       (INIT),
    .REF_IN     (REF_IN),
    .REF_OUT    (REF_OUT),
    .XOR_OUT    (XOR_OUT)
  ) u_crc_calc (
    .clk_i        (clk_i),
    .rst_i        (w_crc_rst),
    .soft_reset_i (w_soft_reset),
    .valid_i      (w_accept),
    .data_i       (bus.s_data_i),
    .crc_o        (w_crc)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= PAYLOAD;
      r_byte_cnt  <= '0;
      r_gap_cnt   <= '0;
      r_m_valid   <= 1'b0;
      r_m_data    <= '0;
      r_m_last    <= 1'b0;
      r_err       <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        PAYLOAD: begin
          if (w_accept) begin
            r_m_valid  <= 1'b1;
            r_m_data   <= bus.s_data_i;
            r_m_last   <= 1'b0;
            r_byte_cnt <= w_cnt_next;
            if (bus.s_last_i || w_hit_max) r_state <= APPEND;
            // Leftover bytes of a truncated frame start a fresh frame
            r_err <= w_hit_max & !bus.s_last_i;
          end else if (bus.m_ready_i) begin
            r_m_valid <= 1'b0;
          end
        end
        APPEND: begin
          if (w_slot_free) begin
            r_m_valid  <= 1'b1;
            r_m_data   <= w_crc;
            r_m_last   <= 1'b1;
            r_byte_cnt <= '0;
            r_state    <= DRAIN;
          end
        end
        DRAIN: begin
          if (bus.m_ready_i) begin
            r_m_valid   <= 1'b0;
            r_m_last    <= 1'b0;
            r_frame_cnt <= r_frame_cnt + 1'b1;
            if (GAP == 0) begin
              r_state <= PAYLOAD;
            end else begin
              r_gap_cnt <= C_GAP;
              r_state   <= GAP_WAIT;
            end
          end
        end
        GAP_WAIT: begin
          r_gap_cnt <= r_gap_cnt - 1'b1;
          if (r_gap_cnt == C_GAP_ONE) r_state <= PAYLOAD;
        end
        default: r_state <= PAYLOAD;
      endcase
    end
  end

  assign bus.s_ready_o      = w_s_ready;
  assign bus.m_valid_o      = r_m_valid;
  assign bus.m_data_o       = r_m_data;
  assign bus.m_last_o       = r_m_last;
  assign bus.busy_o         = (r_state != PAYLOAD) | (r_byte_cnt != '0);
  assign bus.err_oversize_o = r_err;
  assign bus.frame_count_o  = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_crc8_frame_tx.sv
`default_nettype none
// ============================================================================
// tb_crc8_frame_tx : directed checks of crc8_frame_tx framing, CRC, gap, reset
// Revision 1.0
// ============================================================================
module tb_crc8_frame_tx;

  logic       clk = 1'b0;
  logic       rst_ni;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_last;
  logic       m_ready;
  logic       sel;
  logic       stall_en;

  int n_assert = 0;
  int n_fail   = 0;

  logic [8:0] mon_q[$];
  logic [8:0] exp_q[$];
  int         err_cnt   = 0;
  int         gap_cnt   = 0;
  int         last_gap  = -1;
  bit         measuring = 1'b0;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always #5 clk = ~clk;

  crc8_frame_tx_if bus  ();
  crc8_frame_tx_if bus4 ();

  crc8_frame_tx dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  crc8_frame_tx #(.MAX_LEN(4)) dut4 (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus4)
  );

  assign bus.s_valid_i  = s_valid & !sel;
  assign bus.s_data_i   = s_data;
  assign bus.s_last_i   = s_last;
  assign bus.m_ready_i  = m_ready;
  assign bus4.s_valid_i = s_valid & sel;
  assign bus4.s_data_i  = s_data;
  assign bus4.s_last_i  = s_last;
  assign bus4.m_ready_i = m_ready;

  wire        w_mv    = sel ? bus4.m_valid_o      : bus.m_valid_o;
  wire [7:0]  w_md    = sel ? bus4.m_data_o       : bus.m_data_o;
  wire        w_ml    = sel ? bus4.m_last_o       : bus.m_last_o;
  wire        w_sr    = sel ? bus4.s_ready_o      : bus.s_ready_o;
  wire        w_err   = sel ? bus4.err_oversize_o : bus.err_oversize_o;
  wire        w_busy  = sel ? bus4.busy_o         : bus.busy_o;
  wire [15:0] w_cnt   = sel ? bus4.frame_count_o  : bus.frame_count_o;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: captures handshakes, checks stall stability, measures the gap
  always @(negedge clk) begin
    if (!rst_ni) begin
      prev_stall = 1'b0;
      measuring  = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 32'(w_mv), 32'd1);
        chk("stall_data", 32'(w_md), 32'(prev_data));
      end
      prev_stall = w_mv & !m_ready;
      prev_data  = w_md;
      if (w_err) err_cnt++;
      if (measuring) begin
        if (!w_sr) gap_cnt++;
        else begin
          measuring = 1'b0;
          last_gap  = gap_cnt;
        end
      end
      if (w_mv & m_ready) begin
        mon_q.push_back({w_ml, w_md});
        if (w_ml) begin
          measuring = 1'b1;
          gap_cnt   = 0;
        end
      end
    end
  end

  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic l);
    bit got = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (w_sr) got = 1'b1;
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (!got) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_frame(input logic [7:0] b[$]);
    for (int i = 0; i < b.size(); i++) send_byte(b[i], i == b.size() - 1);
  endtask

  task automatic check_frame(input string tag);
    int n = exp_q.size();
    logic [8:0] obs;
    for (int i = 0; i < 400 && mon_q.size() < n; i++) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      obs = (mon_q.size() > 0) ? mon_q.pop_front() : 9'bx;
      chk(tag, 32'(obs), 32'(exp_q[i]));
    end
    exp_q.delete();
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (!w_busy) done = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("idle_timeout", 32'(done), 32'd1);
  endtask

  initial begin
    rst_ni   = 1'b0;
    s_valid  = 1'b0;
    s_data   = 8'h00;
    s_last   = 1'b0;
    sel      = 1'b0;
    stall_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_ready", 32'(bus.s_ready_o), 32'd0);
    chk("rst_s_ready4", 32'(bus4.s_ready_o), 32'd0);
    chk("rst_m_valid", 32'(bus.m_valid_o), 32'd0);
    chk("rst_m_data", 32'(bus.m_data_o), 32'd0);
    chk("rst_m_last", 32'(bus.m_last_o), 32'd0);
    chk("rst_busy", 32'(bus.busy_o), 32'd0);
    chk("rst_err", 32'(bus.err_oversize_o), 32'd0);
    chk("rst_count", 32'(bus.frame_count_o), 32'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    @(posedge clk);
    #1;

    // FF,FF -> CRC 23
    send_byte(8'hFF, 1'b0);
    chk("busy_mid_frame", 32'(w_busy), 32'd1);
    send_byte(8'hFF, 1'b1);
    exp_q = '{9'h0FF, 9'h0FF, 9'h123};
    check_frame("ffff_frame");
    wait_idle();
    chk("count_1", 32'(w_cnt), 32'd1);

    // Single byte frame CD -> CD,F1, then a 2-cycle gap
    send_byte(8'hCD, 1'b1);
    exp_q = '{9'h0CD, 9'h1F1};
    check_frame("single_frame");
    wait_idle();
    chk("gap_cycles", 32'(last_gap), 32'd2);
    chk("count_2", 32'(w_cnt), 32'd2);

    // Back-to-back frames: second CRC proves the engine was cleared
    send_frame('{8'h12, 8'hAB, 8'h34, 8'hCD});
    send_frame('{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39});
    exp_q = '{9'h012, 9'h0AB, 9'h034, 9'h0CD, 9'h16B};
    check_frame("b2b_frame_a");
    exp_q = '{9'h031, 9'h032, 9'h033, 9'h034, 9'h035, 9'h036, 9'h037, 9'h038, 9'h039, 9'h197};
    check_frame("b2b_frame_b");
    wait_idle();
    chk("count_4", 32'(w_cnt), 32'd4);

    // Same frame under random downstream stalls
    stall_en = 1'b1;
    send_frame('{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39});
    exp_q = '{9'h031, 9'h032, 9'h033, 9'h034, 9'h035, 9'h036, 9'h037, 9'h038, 9'h039, 9'h197};
    check_frame("stall_frame");
    stall_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    wait_idle();
    chk("count_5", 32'(w_cnt), 32'd5);
    chk("no_err_main", 32'(err_cnt), 32'd0);

    // MAX_LEN=4 instance: forced termination, remainder reframed
    sel     = 1'b1;
    err_cnt = 0;
    @(posedge clk);
    #1;
    send_frame('{8'h12, 8'hAB, 8'h34, 8'hCD, 8'h31, 8'h32});
    exp_q = '{9'h012, 9'h0AB, 9'h034, 9'h0CD, 9'h16B};
    check_frame("oversize_first");
    exp_q = '{9'h031, 9'h032, 9'h10E};
    check_frame("oversize_rest");
    wait_idle();
    chk("oversize_err_pulses", 32'(err_cnt), 32'd1);
    chk("count4_2", 32'(w_cnt), 32'd2);
    sel = 1'b0;
    @(posedge clk);
    #1;

    // Asynchronous reset in the middle of a frame
    send_byte(8'h12, 1'b0);
    send_byte(8'hAB, 1'b0);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("arst_m_valid", 32'(bus.m_valid_o), 32'd0);
    chk("arst_m_data", 32'(bus.m_data_o), 32'd0);
    chk("arst_busy", 32'(bus.busy_o), 32'd0);
    chk("arst_s_ready", 32'(bus.s_ready_o), 32'd0);
    chk("arst_count", 32'(bus.frame_count_o), 32'd0);
    mon_q.delete();
    @(negedge clk);
    rst_ni = 1'b1;
    @(posedge clk);
    #1;
    send_frame('{8'hFF, 8'hFF});
    exp_q = '{9'h0FF, 9'h0FF, 9'h123};
    check_frame("post_reset_frame");
    wait_idle();
    chk("post_reset_count", 32'(w_cnt), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
